// File: rtl/bytecode_fetch.sv
// Bytecode fetch: reads byte-wide program memory (1-cycle sync read), gathers 0-2 big-endian
// argument bytes per opcode and offers the instruction over valid/ready; redirects apply at transfer.
module bytecode_fetch #(
  parameter int                    ADDR_WIDTH = 11,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  output logic [7:0]            opcode,
  input  logic [1:0]            argc,
  output logic [15:0]           arg,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_CAP_OP    = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_CAP_ARG1  = 3'd3;
  localparam logic [2:0] S_WAIT_ARG2 = 3'd4;
  localparam logic [2:0] S_CAP_ARG2  = 3'd5;
  localparam logic [2:0] S_DISPATCH  = 3'd6;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [15:0]           arg_q, arg_d;
  logic                  two_args;

  // argc of 3 is treated as 2, so the high bit alone selects the second byte
  assign two_args = argc[1];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    opcode_d   = opcode_q;
    arg_d      = arg_q;
    case (state_q)
      S_FETCH: state_d = S_CAP_OP;
      S_CAP_OP: begin
        opcode_d   = mem_data;
        instr_pc_d = pc_q;
        arg_d      = 16'h0000;
        pc_d       = pc_q + PC_ONE;
        state_d    = S_DECODE;
      end
      S_DECODE: state_d = (argc == 2'd0) ? S_DISPATCH : S_CAP_ARG1;
      S_CAP_ARG1: begin
        arg_d   = {8'h00, mem_data};
        pc_d    = pc_q + PC_ONE;
        state_d = two_args ? S_WAIT_ARG2 : S_DISPATCH;
      end
      S_WAIT_ARG2: state_d = S_CAP_ARG2;
      S_CAP_ARG2: begin
        arg_d   = {arg_q[7:0], mem_data};
        pc_d    = pc_q + PC_ONE;
        state_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (instr_ready) begin
          if (jump) pc_d = jump_target;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_pc_q <= RESET_PC;
      opcode_q   <= 8'h00;
      arg_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      opcode_q   <= opcode_d;
      arg_q      <= arg_d;
    end
  end

  assign mem_addr    = pc_q;
  assign opcode      = opcode_q;
  assign arg         = arg_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == S_DISPATCH);

endmodule

// File: tb/tb_bytecode_fetch.sv
// Bench for bytecode_fetch: directed program scenarios plus random programs, checked against an
// instruction-level model (memory array, PC, argc table, latency rule).
module tb_bytecode_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, instr_ready, jump, force3, rand_dec, sel;
  logic [10:0] jump_target;
  logic [7:0]  mem [0:2047];

  logic [10:0] a_mem_addr, a_instr_pc;
  logic [7:0]  a_mem_data, a_opcode;
  logic [1:0]  a_argc;
  logic [15:0] a_arg;
  logic        a_valid;

  logic [3:0]  b_mem_addr, b_instr_pc;
  logic [7:0]  b_mem_data, b_opcode;
  logic [1:0]  b_argc;
  logic [15:0] b_arg;
  logic        b_valid;

  bytecode_fetch #(.ADDR_WIDTH(11), .RESET_PC(11'd0)) dut_a (
    .clk(clk), .rst(rst), .mem_addr(a_mem_addr), .mem_data(a_mem_data), .opcode(a_opcode),
    .argc(a_argc), .arg(a_arg), .instr_pc(a_instr_pc), .instr_valid(a_valid),
    .instr_ready(instr_ready), .jump(jump), .jump_target(jump_target)
  );

  bytecode_fetch #(.ADDR_WIDTH(4), .RESET_PC(4'd0)) dut_b (
    .clk(clk), .rst(rst), .mem_addr(b_mem_addr), .mem_data(b_mem_data), .opcode(b_opcode),
    .argc(b_argc), .arg(b_arg), .instr_pc(b_instr_pc), .instr_valid(b_valid),
    .instr_ready(instr_ready), .jump(jump), .jump_target(jump_target[3:0])
  );

  always @(posedge clk) begin
    a_mem_data <= mem[a_mem_addr];
    b_mem_data <= mem[{7'd0, b_mem_addr}];
  end

  // Decoder stand-in: small opcode table, or argc = low opcode bits for random programs
  function automatic logic [1:0] dec_argc(input logic [7:0] op, input logic f3, input logic rnd);
    if (f3) return 2'd3;
    if (rnd) return op[1:0];
    if (op == 8'h10) return 2'd1;
    if (op == 8'h11 || (op >= 8'h99 && op <= 8'hA7)) return 2'd2;
    return 2'd0;
  endfunction

  assign a_argc = dec_argc(a_opcode, force3, rand_dec);
  assign b_argc = dec_argc(b_opcode, force3, rand_dec);

  logic [10:0] o_mem_addr, o_instr_pc, pc_mask;
  logic [7:0]  o_opcode;
  logic [15:0] o_arg;
  logic        o_valid;
  assign o_mem_addr = sel ? {7'd0, b_mem_addr} : a_mem_addr;
  assign o_instr_pc = sel ? {7'd0, b_instr_pc} : a_instr_pc;
  assign o_opcode   = sel ? b_opcode : a_opcode;
  assign o_arg      = sel ? b_arg : a_arg;
  assign o_valid    = sel ? b_valid : a_valid;
  assign pc_mask    = sel ? 11'h00F : 11'h7FF;

  int checks = 0;
  int failures = 0;
  logic [10:0] m_pc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1; instr_ready = 1'b0; jump = 1'b0;
    repeat (cyc) step();
    chk("reset_state", {o_valid, o_opcode, o_arg, o_instr_pc, o_mem_addr}, 64'd0);
    rst = 1'b0;
    m_pc = 11'd0;
  endtask

  // Starting in FETCH: wait for the instruction, check it, stall, then transfer
  task automatic do_instr(input string tag, input int stall, input logic jmp,
                          input logic [10:0] tgt, input logic stall_jmp);
    logic [7:0]  op;
    logic [15:0] a;
    logic [10:0] nxt;
    int n, lat, waited;
    op = mem[m_pc];
    n  = int'(dec_argc(op, force3, rand_dec));
    if (n > 2) n = 2;
    a = 16'h0000;
    if (n >= 1) a = {8'h00, mem[(m_pc + 11'd1) & pc_mask]};
    if (n == 2) a = {a[7:0], mem[(m_pc + 11'd2) & pc_mask]};
    lat = (n == 0) ? 3 : (n == 1) ? 4 : 6;
    nxt = (m_pc + 11'(1 + n)) & pc_mask;
    instr_ready = 1'b0; jump = 1'b0;
    waited = 0;
    while (o_valid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    chk({tag, "_latency"}, 64'(waited), 64'(lat));
    chk({tag, "_instr"}, {o_opcode, o_arg, o_instr_pc, o_mem_addr}, {op, a, m_pc, nxt});
    repeat (stall) begin
      jump = stall_jmp; jump_target = tgt;
      step();
      chk({tag, "_stall"}, {o_valid, o_opcode, o_arg, o_instr_pc, o_mem_addr},
          {1'b1, op, a, m_pc, nxt});
    end
    instr_ready = 1'b1; jump = jmp; jump_target = tgt;
    step();
    instr_ready = 1'b0; jump = 1'b0;
    if (jmp) nxt = tgt & pc_mask;
    chk({tag, "_after_xfer"}, {o_valid, o_mem_addr}, {1'b0, nxt});
    m_pc = nxt;
  endtask

  initial begin
    rst = 1'b1; instr_ready = 1'b0; jump = 1'b0; jump_target = 11'd0;
    force3 = 1'b0; rand_dec = 1'b0; sel = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

    // reset with all-NOP memory
    do_reset(3);
    do_instr("nop0", 0, 1'b0, 11'd0, 1'b0);

    // ICONST_1, BIPUSH, SIPUSH back to back with ready high
    mem[0] = 8'h04; mem[1] = 8'h10; mem[2] = 8'h7F;
    mem[3] = 8'h11; mem[4] = 8'h12; mem[5] = 8'h34;
    do_reset(1);
    do_instr("iconst", 0, 1'b0, 11'd0, 1'b0);
    do_instr("bipush", 0, 1'b0, 11'd0, 1'b0);
    do_instr("sipush", 0, 1'b0, 11'd0, 1'b0);
    chk("seq_next_pc", 64'(m_pc), 64'd6);

    // backpressure, then GOTO with jump ignored while stalled, then IFEQ not taken
    mem[0] = 8'h11; mem[1] = 8'hAB; mem[2] = 8'hCD;
    mem[3] = 8'h10; mem[4] = 8'h01;
    mem[5] = 8'h00; mem[6] = 8'h04; mem[7] = 8'h04;
    mem[8] = 8'hA7; mem[9] = 8'hFF; mem[10] = 8'hFD;
    do_reset(1);
    do_instr("bp_sipush", 5, 1'b0, 11'd0, 1'b0);
    do_instr("bipush2", 0, 1'b0, 11'd0, 1'b0);
    repeat (3) do_instr("fill", 0, 1'b0, 11'd0, 1'b0);
    do_instr("goto", 3, 1'b1, 11'd5, 1'b1);
    mem[8] = 8'h99; mem[9] = 8'h00; mem[10] = 8'h05;
    do_instr("goto_dest", 0, 1'b0, 11'd0, 1'b0);
    repeat (2) do_instr("fill2", 0, 1'b0, 11'd0, 1'b0);
    do_instr("ifeq_nt", 1, 1'b0, 11'd3, 1'b1);
    do_instr("after_ifeq", 0, 1'b0, 11'd0, 1'b0);

    // PC wrap on the 4-bit instance
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h78; mem[14] = 8'h11; mem[15] = 8'h56;
    sel = 1'b1;
    do_reset(1);
    repeat (14) do_instr("wrap_fill", 0, 1'b0, 11'd0, 1'b0);
    do_instr("wrap_sipush", 0, 1'b0, 11'd0, 1'b0);
    chk("wrap_next_pc", 64'(m_pc), 64'd1);
    do_instr("wrap_after", 0, 1'b0, 11'd0, 1'b0);
    sel = 1'b0;

    // reset while waiting for the second argument byte
    mem[0] = 8'h04; mem[1] = 8'h10; mem[2] = 8'h44;
    mem[3] = 8'h11; mem[4] = 8'h22; mem[5] = 8'h33;
    do_reset(1);
    do_instr("mid_a", 0, 1'b0, 11'd0, 1'b0);
    do_instr("mid_b", 0, 1'b0, 11'd0, 1'b0);
    instr_ready = 1'b1;
    repeat (4) step();
    chk("mid_wait_arg2", {o_valid, o_arg, o_mem_addr}, {1'b0, 16'h0022, 11'd5});
    rst = 1'b1;
    step();
    rst = 1'b0; instr_ready = 1'b0; m_pc = 11'd0;
    chk("mid_reset", {o_valid, o_opcode, o_arg, o_instr_pc, o_mem_addr}, 64'd0);
    mem[1] = 8'h9A; mem[2] = 8'hBC;
    force3 = 1'b1;
    do_instr("argc3", 0, 1'b0, 11'd0, 1'b0);
    force3 = 1'b0;

    // random programs, random stalls and redirects on both widths
    rand_dec = 1'b1;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      do_reset(2);
      for (int k = 0; k < ((s == 0) ? 150 : 60); k++) begin
        do_instr("rand", int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 11'($urandom), 1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bytecode_fetch.md
# bytecode_fetch

Instruction fetch unit feeding the bytecode decoder: reads byte-wide program memory, presents each opcode to the decoder, collects the 0–2 inline argument bytes the decoder reports via `argc`, and hands a complete instruction (opcode, argument, opcode address) to the execute stage over a valid/ready handshake. It owns the program counter and applies control-flow redirects (GOTO, taken IF*) supplied by the execute stage at instruction accept.

## Interface
- `ADDR_WIDTH`, 11, program memory byte-address width; PC wraps modulo 2^ADDR_WIDTH
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `mem_addr`  out  ADDR_WIDTH  program memory read address; equals PC register
- `mem_data`  in  8  program byte; `mem[mem_addr]` from cycle N is valid during cycle N+1 (1-cycle synchronous read)
- `opcode`  out  8  current opcode, to decoder; registered
- `argc`  in  2  argument byte count from decoder, combinational from `opcode`; 3 treated as 2
- `arg`  out  16  assembled argument bytes
- `instr_pc`  out  ADDR_WIDTH  address of current opcode byte (branch base)
- `instr_valid`  out  1  `opcode`/`arg`/`instr_pc` form a complete instruction
- `instr_ready`  in  1  execute stage accepts; transfer when `instr_valid & instr_ready`
- `jump`  in  1  redirect request, sampled only at transfer
- `jump_target`  in  ADDR_WIDTH  address of next opcode when `jump` taken

## Operation
- States: FETCH, CAP_OP, DECODE, CAP_ARG1, WAIT_ARG2, CAP_ARG2, DISPATCH.
- FETCH: `mem_addr`=PC=A. -> CAP_OP.
- CAP_OP: `opcode`<=`mem_data`, `instr_pc`<=A, `arg`<=0, PC<=A+1. -> DECODE.
- DECODE: decoder output `argc` now valid. argc=0 -> DISPATCH; else -> CAP_ARG1.
- CAP_ARG1: `arg`<={8'h00, `mem_data`}, PC<=PC+1. argc=1 -> DISPATCH; else -> WAIT_ARG2.
- WAIT_ARG2: address settles. -> CAP_ARG2.
- CAP_ARG2: `arg`<={`arg[7:0]`, `mem_data`} (big-endian, first byte high), PC<=PC+1. -> DISPATCH.
- DISPATCH: `instr_valid`=1. Without `instr_ready`: hold state, all outputs stable. With `instr_ready`: if `jump`, PC<=`jump_target`; else PC unchanged (already points past the args). -> FETCH.
- `arg` is never sign-extended here; sign/offset interpretation belongs to execute.
- `jump` outside DISPATCH, or in DISPATCH with `instr_ready`=0: ignored, no side effect.
- PC increments wrap: A=2^ADDR_WIDTH-1 increments to 0.
- `opcode` changes only in CAP_OP; `arg` only in CAP_OP/CAP_ARG1/CAP_ARG2; `instr_pc` only in CAP_OP.

## Timing
- Reset values: state FETCH, PC/`mem_addr`=RESET_PC, `opcode`=8'h00 (NOP), `arg`=16'h0000, `instr_pc`=RESET_PC, `instr_valid`=0.
- Reset at any state, including DISPATCH or mid-argument: partial instruction discarded, no transfer; first cycle after `rst` falls is FETCH at RESET_PC.
- Cycles from FETCH to first `instr_valid`: argc=0 -> 3, argc=1 -> 4, argc=2 -> 6.
- Throughput with `instr_ready` tied high: one instruction per 4/5/7 cycles for argc 0/1/2.
- `instr_valid` is a registered state decode; never depends combinationally on `instr_ready` or `jump`.
- Once asserted, `instr_valid` stays high until transfer or reset.
- Cycle after transfer is always FETCH with `mem_addr` = redirected or sequential PC.

## Test plan
- Reset: memory all 0x00, hold `rst` 3 cycles -> `mem_addr`=0, `opcode`=0x00, `arg`=0, `instr_valid`=0; after release, `instr_valid` rises 3 cycles later with `instr_pc`=0.
- ICONST_1/BIPUSH/SIPUSH: memory 0x04, 0x10 0x7F, 0x11 0x12 0x34 from addr 0, ready high -> transfers (0x04, 0x0000, pc 0), (0x10, 0x007F, pc 1), (0x11, 0x1234, pc 3); spacing 4, 5, 7 cycles; next fetch at 6.
- Backpressure: `instr_ready` low 5 cycles in DISPATCH for SIPUSH 0x11 0xAB 0xCD -> `opcode`/`arg`=0xABCD/`instr_pc`/`mem_addr` stable, `instr_valid` high; exactly one transfer on ready.
- Redirect: GOTO 0xA7 0xFF 0xFD at addr 8, `jump`=1 `jump_target`=5 while ready low (ignored), then with ready high -> next `mem_addr`=5, next `instr_pc`=5; IFEQ 0x99 0x00 0x05 accepted with `jump`=0 -> next `instr_pc`=11.
- Wrap: ADDR_WIDTH=4, SIPUSH 0x11 at 0xE, args 0x56 at 0xF, 0x78 at 0x0 -> `arg`=0x5678, next `instr_pc`=0x1.
- Reset mid-operation: assert `rst` in WAIT_ARG2 of SIPUSH at addr 3 -> no transfer, next instruction fetched from RESET_PC with `arg` cleared; `argc`=3 forced from bench -> behaves as argc=2.
